energy_window_det: RTL and testbench

Windowed energy detector that consumes the 8-bit sample stream produced by the `flip_t` stage. It is clocked by the same clock and qualified by the same `clk_en`. Each accepted sample is squared, and the squares are summed over non-overlapping windows of 2^WIN_LOG2 samples. Each window total is published with a one-cycle valid strobe, and the totals drive a hysteresis detect flag.

---
 rtl/energy_window_det.sv | 96 +++++++++
 tb/tb_energy_window_det.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/energy_window_det.sv
// Windowed sum-of-squares energy detector with a hysteresis detect flag.
// Samples are squared, summed over 2^WIN_LOG2 accepted samples, and each window total is published.
module energy_window_det #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 4,
    parameter int ACC_W    = 2*DATA_W + WIN_LOG2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ACC_W-1:0]  thresh_hi,
    input  logic [ACC_W-1:0]  thresh_lo,
    output logic [ACC_W-1:0]  energy_out,
    output logic              energy_valid,
    output logic              detect
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic signed [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0]        sq_reg;
    logic                       sq_vld_reg;
    logic [ACC_W-1:0]           acc_reg;
    logic [WIN_LOG2-1:0]        cnt_reg;
    logic [ACC_W-1:0]           energy_reg;
    logic                       energy_valid_reg;
    logic [ACC_W-1:0]           acc_sum;
    logic                       win_last;
    state_t                     state_reg;
    state_t                     state_next;

    // The square of a DATA_W two's-complement value always fits as unsigned in 2*DATA_W bits.
    assign prod     = $signed(data_in) * $signed(data_in);
    assign acc_sum  = acc_reg + ACC_W'(sq_reg);
    assign win_last = &cnt_reg;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sq_reg     <= '0;
            sq_vld_reg <= 1'b0;
        end else if (clk_en) begin
            sq_reg     <= prod;
            sq_vld_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            cnt_reg    <= '0;
            energy_reg <= '0;
        end else if (clk_en && sq_vld_reg) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (win_last) begin
                energy_reg <= acc_sum;
                acc_reg    <= '0;
            end else begin
                acc_reg <= acc_sum;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            energy_valid_reg <= 1'b0;
        end else begin
            energy_valid_reg <= clk_en & sq_vld_reg & win_last;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Only the threshold belonging to the current state is consulted.
    always_comb begin
        state_next = state_reg;
        if (energy_valid_reg) begin
            case (state_reg)
                IDLE:    if (energy_reg > thresh_hi) state_next = ACTIVE;
                ACTIVE:  if (energy_reg < thresh_lo) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign energy_out   = energy_reg;
    assign energy_valid = energy_valid_reg;
    assign detect       = (state_reg == ACTIVE);

endmodule

// File: tb/tb_energy_window_det.sv
// Scoreboard bench for energy_window_det: directed windows push expected totals,
// a monitor pops them on each energy_valid and checks detect one clock later.
module tb_energy_window_det;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [19:0] thresh_hi = '0;
    logic [19:0] thresh_lo = '0;
    logic [19:0] energy_out;
    logic        energy_valid;
    logic        detect;

    typedef struct {
        logic [19:0] energy;
        logic        det;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   valid_cnt = 0;

    energy_window_det #(.DATA_W(8), .WIN_LOG2(4), .ACC_W(20)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .data_in      (data_in),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .energy_out   (energy_out),
        .energy_valid (energy_valid),
        .detect       (detect)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s: %0d", name, act);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic en);
        data_in = d;
        clk_en  = en;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'($urandom), 1'b0);
    endtask

    task automatic window(input logic [7:0] d);
        for (int i = 0; i < 16; i++) send(d, 1'b1);
    endtask

    task automatic expect_win(input logic [19:0] e, input logic det);
        exp_t x;
        x.energy = e;
        x.det    = det;
        q.push_back(x);
    endtask

    task automatic do_reset();
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops one expectation per energy_valid; detect checked on the following cycle.
    initial begin
        logic pend = 1'b0;
        logic pend_det = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (pend) begin
                check("detect_after_valid", 32'(detect), 32'(pend_det));
                pend = 1'b0;
            end
            if (energy_valid) begin
                valid_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_valid_energy", 32'(energy_out), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("energy_out", 32'(energy_out), 32'(e.energy));
                    pend_det = e.det;
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        do_reset();

        // Constant +10, thresholds 1000/500 -> 1600 and detect asserts.
        thresh_hi = 20'd1000;
        thresh_lo = 20'd500;
        window(8'd10);
        expect_win(20'd1600, 1'b1);
        send(8'd0, 1'b1);
        idle(4);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(posedge clock);
        #3 rst_n = 1'b0;
        #1;
        check("rst_energy_out", 32'(energy_out), 32'd0);
        check("rst_energy_valid", 32'(energy_valid), 32'd0);
        check("rst_detect", 32'(detect), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        idle(2);

        // Full scale, detect never asserts.
        do_reset();
        thresh_hi = 20'hFFFFF;
        thresh_lo = 20'd0;
        window(8'h80);
        expect_win(20'd262144, 1'b0);
        for (int i = 0; i < 16; i++) send((i % 2) ? 8'h81 : 8'h7F, 1'b1);
        expect_win(20'd258064, 1'b0);
        send(8'd0, 1'b1);
        idle(4);

        // Hysteresis sequence.
        do_reset();
        thresh_hi = 20'd1000;
        thresh_lo = 20'd500;
        window(8'd10);
        expect_win(20'd1600, 1'b1);
        window(8'd7);
        expect_win(20'd784, 1'b1);
        window(8'd5);
        expect_win(20'd400, 1'b0);
        window(8'd7);
        expect_win(20'd784, 1'b0);
        send(8'd0, 1'b1);
        idle(4);

        // clk_en gaps, including right after the 15th sample and before the flush.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'd3, 1'b1);
            if (i == 2 || i == 7 || i == 14) idle(1 + (i % 3));
        end
        expect_win(20'd144, 1'b0);
        idle(2);
        send(8'd0, 1'b1);
        idle(6);
        check("hold_energy_in_gaps", 32'(energy_out), 32'd144);

        // Reset mid-window discards the partial window.
        do_reset();
        thresh_hi = 20'd1000;
        thresh_lo = 20'd500;
        for (int i = 0; i < 9; i++) send(8'd20, 1'b1);
        do_reset();
        window(8'd2);
        expect_win(20'd64, 1'b0);
        send(8'd0, 1'b1);
        idle(4);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clock);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        check("valid_pulse_count", 32'(valid_cnt), 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
